// File: rtl/apb_req_master.sv
// APB3 initiator bridging a single-outstanding req/gnt/rvalid port
// onto SETUP/ACCESS transfers, with misalignment and PREADY timeout.
`timescale 1ns/1ps
module apb_req_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [CW-1:0]             cnt_q;
    logic                      load;
    logic                      cnt_clr;
    logic                      cnt_inc;
    logic                      resp;
    logic                      resp_err;
    logic [APB_DATA_WIDTH-1:0] resp_data;
    logic                      misaligned;

    assign misaligned = (addr_i[1:0] != 2'b00);

    // Next-state, handshake and APB phase decode
    always_comb begin
        state_d   = state_q;
        gnt_o     = 1'b0;
        load      = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        resp      = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i && rst_ni) begin
                    gnt_o = 1'b1;
                    load  = 1'b1;
                    if (misaligned) begin
                        state_d = ERR;
                    end else begin
                        state_d = SETUP;
                        cnt_clr = 1'b1;
                    end
                end
            end
            SETUP: begin
                psel_o  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i) begin
                    resp      = 1'b1;
                    resp_err  = pslverr_i;
                    resp_data = pwrite_o ? '0 : prdata_i;
                    state_d   = IDLE;
                end else if (TO_EN && (cnt_q == TO_VAL)) begin
                    resp     = 1'b1;
                    resp_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                resp     = 1'b1;
                resp_err = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request; held until the next grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            paddr_o  <= '0;
            pwdata_o <= '0;
            pwrite_o <= 1'b0;
        end else if (load) begin
            paddr_o  <= addr_i;
            pwdata_o <= wdata_i;
            pwrite_o <= we_i;
        end
    end

    // ACCESS wait counter; saturates instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response strobe; data and error hold until the next response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= resp;
            if (resp) begin
                rdata_o <= resp_data;
                err_o   <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed plus randomized bench for apb_req_master against a
// transaction-level latency/response model.
`timescale 1ns/1ps
module tb_apb_req_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    apb_req_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .pwrite_o (pwrite),
        .psel_o   (psel),
        .penable_o(penable),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_paddr"}, 64'(paddr), 64'd0);
        chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
        chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
        chk({tag, "_sel"}, 64'({psel, penable}), 64'd0);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    endtask

    // Issue one request at the current negedge (cycle T) and follow it
    // until the response. waits = ACCESS cycles with pready low first.
    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] prd, input logic slv);
        logic        mis;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          cyc;
        bit          done;
        bit          rdy;
        mis = (a[1:0] != 2'b00);
        if (mis) begin
            lat = 2;
            exp_rd = '0;
            exp_err = 1'b1;
        end else if (waits > TMO) begin
            lat = 3 + TMO;
            exp_rd = '0;
            exp_err = 1'b1;
        end else begin
            lat = 3 + waits;
            exp_rd = w ? 32'd0 : prd;
            exp_err = slv;
        end
        req = 1'b1;
        we = w;
        addr = a;
        wdata = wd;
        pready = 1'b0;
        #1;
        chk("gnt", 64'(gnt), 64'd1);
        @(negedge clk);
        cyc = 1;
        done = 0;
        while (!done) begin
            if (rvalid) begin
                chk("latency", 64'(cyc), 64'(lat));
                chk("rdata", 64'(rdata), 64'(exp_rd));
                chk("err", 64'(err), 64'(exp_err));
                chk("sel_resp", 64'({psel, penable}), 64'd0);
                req = 1'b0;
                pready = 1'b0;
                done = 1;
            end else if (cyc > lat) begin
                chk("resp_timeout", 64'(cyc), 64'(lat));
                req = 1'b0;
                done = 1;
            end else begin
                chk("gnt_busy", 64'(gnt), 64'd0);
                chk("hold_rdata", 64'(rdata), 64'(last_rd));
                chk("hold_err", 64'(err), 64'(last_err));
                chk("paddr", 64'(paddr), 64'(a));
                chk("pwrite", 64'(pwrite), 64'(w));
                chk("pwdata", 64'(pwdata), 64'(wd));
                if (mis)
                    chk("sel_mis", 64'({psel, penable}), 64'd0);
                else if (cyc == 1)
                    chk("sel_setup", 64'({psel, penable}), 64'd2);
                else
                    chk("sel_access", 64'({psel, penable}), 64'd3);
                req = 1'($urandom);
                we = 1'($urandom);
                addr = $urandom;
                wdata = $urandom;
                if (!mis && cyc >= 2) begin
                    rdy = (cyc - 2 == waits);
                    pready = rdy;
                    prdata = rdy ? prd : $urandom;
                    pslverr = rdy ? slv : 1'($urandom);
                end else begin
                    pready = 1'($urandom);
                    prdata = $urandom;
                    pslverr = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        last_rd = exp_rd;
        last_err = exp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = 1'b1;
        we = 1'b1;
        addr = 32'h1A10_0000;
        wdata = 32'hFFFF_FFFF;
        prdata = '0;
        pready = 1'b0;
        pslverr = 1'b0;
        #1;
        chk_reset_outs("reset");
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_hold");
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait read
        xfer(1'b0, 32'h1A10_0000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        // write with 3 wait states, back-to-back
        xfer(1'b1, 32'h1A10_0004, 32'h1234_5678, 3, 32'hCAFE_F00D, 1'b0);
        // slave error, then back-to-back read
        xfer(1'b0, 32'h1A10_1000, 32'h0, 1, 32'h5555_AAAA, 1'b1);
        xfer(1'b0, 32'h1A10_1004, 32'h0, 0, 32'h0BAD_C0DE, 1'b0);
        // misaligned
        xfer(1'b1, 32'h1A10_0002, 32'h7777_7777, 0, 32'h0, 1'b0);
        // timeout with pready stuck low
        xfer(1'b0, 32'h1A10_0008, 32'h0, 1000, 32'h0, 1'b0);
        pready = 1'b1;
        pslverr = 1'b0;
        prdata = 32'hFEED_FACE;
        @(negedge clk);
        chk("late_sel", 64'({psel, penable}), 64'd0);
        chk("late_rvalid", 64'(rvalid), 64'd0);
        chk("late_rdata", 64'(rdata), 64'd0);
        chk("late_err", 64'(err), 64'd1);
        pready = 1'b0;
        @(negedge clk);
        chk("late_rvalid2", 64'(rvalid), 64'd0);

        // reset during ACCESS
        req = 1'b1;
        we = 1'b1;
        addr = 32'h1A10_2000;
        wdata = 32'hABCD_0123;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("pre_rst_access", 64'({psel, penable}), 64'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        req = 1'b1;
        @(negedge clk);
        chk("mid_reset_gnt", 64'(gnt), 64'd0);
        req = 1'b0;
        rst_n = 1'b1;
        last_rd = '0;
        last_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rvalid", 64'(rvalid), 64'd0);
            chk("post_rst_sel", 64'({psel, penable}), 64'd0);
        end
        xfer(1'b0, 32'h1A10_3000, 32'h0, 0, 32'h600D_DA7A, 1'b0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            int gap;
            ra = $urandom;
            if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
            xfer(1'($urandom), ra, $urandom, $urandom_range(0, 6),
                 $urandom, 1'($urandom_range(0, 3) == 0));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_rvalid", 64'(rvalid), 64'd0);
                chk("gap_rdata", 64'(rdata), 64'(last_rd));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_master.md
# apb_req_master

APB3 initiator that turns a single-outstanding request/grant/rvalid port (the core-side data request style) into compliant APB SETUP/ACCESS transfers. It sits in front of the peripheral bus node and drives its slave-side APB port, so a master without native APB can reach the UART, GPIO, SPI, timer and other peripherals. It adds misalignment rejection and a programmable PREADY timeout so a hung peripheral cannot stall the requester forever.

## Interface
- APB_ADDR_WIDTH, 32, address width of addr_i and paddr_o
- APB_DATA_WIDTH, 32, data width of wdata_i, rdata_o, pwdata_o, prdata_i
- TIMEOUT_CYCLES, 255, ACCESS-phase wait cycles with pready_i low before abort; 0 disables the timeout
- clk_i  input  1  clock; all state changes on the rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- req_i  input  1  request valid; held until gnt_o
- we_i  input  1  1 = write, 0 = read
- addr_i  input  APB_ADDR_WIDTH  byte address
- wdata_i  input  APB_DATA_WIDTH  write data
- gnt_o  output  1  request accepted this cycle (combinational)
- rvalid_o  output  1  one-cycle response strobe
- rdata_o  output  APB_DATA_WIDTH  read data, valid with rvalid_o
- err_o  output  1  error flag, valid with rvalid_o
- paddr_o  output  APB_ADDR_WIDTH  APB PADDR
- pwdata_o  output  APB_DATA_WIDTH  APB PWDATA
- pwrite_o  output  1  APB PWRITE
- psel_o  output  1  APB PSEL
- penable_o  output  1  APB PENABLE
- prdata_i  input  APB_DATA_WIDTH  APB PRDATA
- pready_i  input  1  APB PREADY
- pslverr_i  input  1  APB PSLVERR

## Operation
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE: gnt_o = req_i. On grant, addr_i, we_i, wdata_i registered into paddr_o/pwrite_o/pwdata_o. If addr_i[1:0] != 0 -> ERR, else -> SETUP.
- SETUP: psel_o=1, penable_o=0; unconditional -> ACCESS.
- ACCESS: psel_o=1, penable_o=1. pready_i=1 -> IDLE; rdata_o <= prdata_i on reads, 0 on writes; err_o <= pslverr_i; rvalid_o <= 1.
- ACCESS with pready_i=0: wait counter increments; when counter equals TIMEOUT_CYCLES (non-zero) -> IDLE with rvalid_o=1, err_o=1, rdata_o=0; psel_o/penable_o drop the next cycle.
- ERR: no APB activity; -> IDLE with rvalid_o=1, err_o=1, rdata_o=0.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1) (min 1), cleared on entering SETUP, saturates, never wraps.
- gnt_o is 0 in SETUP, ACCESS, ERR; exactly one transfer outstanding.
- paddr_o, pwrite_o, pwdata_o held stable from SETUP until the transfer ends; they hold their last value in IDLE.
- psel_o/penable_o are 0 in IDLE and ERR.

## Timing
- Reset values: state IDLE; gnt_o=0 (req_i ignored while rst_ni low), rvalid_o=0, rdata_o=0, err_o=0, paddr_o=0, pwdata_o=0, pwrite_o=0, psel_o=0, penable_o=0, counter=0.
- Grant in cycle T -> SETUP in T+1 -> ACCESS from T+2 -> rvalid_o in the cycle after pready_i is sampled high (T+3 minimum).
- Back-to-back: a new request is granted in the rvalid_o cycle. Minimum issue interval is 3 cycles.
- Misaligned: grant at T, rvalid_o+err_o at T+2, psel_o never asserted.
- Timeout: with pready_i stuck low, rvalid_o+err_o in cycle T+3+TIMEOUT_CYCLES.
- rvalid_o is high exactly one cycle; rdata_o/err_o hold until the next response.
- Reset asserted mid-transfer: psel_o/penable_o clear asynchronously, no rvalid_o is produced, FSM restarts in IDLE.
- pslverr_i and prdata_i are ignored except in an ACCESS cycle with pready_i=1.

## Test plan
- Read, zero-wait: req at 0x1A10_0000, pready=1 in first ACCESS, prdata=0xDEAD_BEEF -> SETUP at T+1, ACCESS at T+2, rvalid at T+3 with rdata=0xDEADBEEF, err=0.
- Write with 3 wait states: wdata=0x1234_5678 -> pwrite=1, paddr/pwdata stable across 4 ACCESS cycles, rvalid at T+6 with err=0 and rdata=0.
- Slave error: pslverr=1 with pready=1 -> rvalid with err=1. A following back-to-back request is granted in the same rvalid cycle.
- Misaligned address 0x1A10_0002 -> gnt at T, no psel, rvalid+err at T+2.
- Timeout: TIMEOUT_CYCLES=4, pready stuck 0 -> rvalid+err=1 at T+7, psel low at T+8. A late pready pulse in IDLE is ignored.
- Reset during ACCESS -> psel/penable low immediately, all outputs at reset values, no rvalid. A normal read after reset completes correctly.
